// File: rtl/uart_loader.sv
// uart_loader: boot-loader command controller.
// Drains bytes from the UART receiver and parses framed WRITE/RUN commands.
// WRITE payload goes to program memory over a byte-write handshake.
// RUN releases the CPU at the host-supplied boot address.
module uart_loader #(
    parameter int ADDR_WIDTH   = 16,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_dout,
    input  logic                  rx_full,
    output logic                  rx_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] boot_addr,
    output logic                  run,
    output logic                  busy,
    output logic                  err
);

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CMD    = 4'd1;
    localparam logic [3:0] ST_ADDR_H = 4'd2;
    localparam logic [3:0] ST_ADDR_L = 4'd3;
    localparam logic [3:0] ST_LEN_H  = 4'd4;
    localparam logic [3:0] ST_LEN_L  = 4'd5;
    localparam logic [3:0] ST_DATA   = 4'd6;
    localparam logic [3:0] ST_WRITE  = 4'd7;
    localparam logic [3:0] ST_CHK    = 4'd8;

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [3:0]            state;
    logic [3:0]            state_n;
    logic                  is_write;
    logic [7:0]            addr_h;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           len_q;
    logic [7:0]            sum_q;
    logic [7:0]            sum_next;
    logic [7:0]            wdata_q;
    logic [ADDR_WIDTH-1:0] boot_q;
    logic                  hold_q;
    logic                  run_q;
    logic                  err_q;
    logic [TW-1:0]         tcnt;
    logic                  timer_on;
    logic                  expired;
    logic                  accept;
    logic                  wr_accept;

    // Handshake qualifiers; a byte arriving on the expiry edge is left for IDLE to parse
    always_comb begin
        timer_on  = (state != ST_IDLE) && (state != ST_WRITE);
        expired   = timer_on && (tcnt == T_LAST);
        accept    = rx_full && (state != ST_WRITE) && !expired;
        wr_accept = (state == ST_WRITE) && mem_ready;
        sum_next  = sum_q + rx_dout;
    end

    // Next-state decode for the frame parser
    always_comb begin
        state_n = state;
        if (expired) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept && rx_dout == SYNC_BYTE) state_n = ST_CMD;
                ST_CMD:    if (accept) state_n = (rx_dout == CMD_WRITE || rx_dout == CMD_RUN)
                                                 ? ST_ADDR_H : ST_IDLE;
                ST_ADDR_H: if (accept) state_n = ST_ADDR_L;
                ST_ADDR_L: if (accept) state_n = is_write ? ST_LEN_H : ST_CHK;
                ST_LEN_H:  if (accept) state_n = ST_LEN_L;
                ST_LEN_L:  if (accept) state_n = ({len_q[15:8], rx_dout} == 16'd0) ? ST_CHK : ST_DATA;
                ST_DATA:   if (accept) state_n = ST_WRITE;
                ST_WRITE:  if (wr_accept) state_n = (len_q == 16'd1) ? ST_CHK : ST_DATA;
                ST_CHK:    if (accept) state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Inter-byte timer: held at zero in IDLE and WRITE, cleared on every accepted byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (accept || !timer_on) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Frame datapath: address/length/checksum capture, write stepping, CPU release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= 1'b0;
            addr_h   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            sum_q    <= '0;
            wdata_q  <= '0;
            boot_q   <= '0;
            hold_q   <= 1'b1;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q <= 1'b0;
            if (expired) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                if (state != ST_IDLE) begin
                    sum_q <= sum_next;
                end
                case (state)
                    ST_IDLE: begin
                        if (rx_dout == SYNC_BYTE) begin
                            err_q <= 1'b0;
                            sum_q <= '0;
                            len_q <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (rx_dout == CMD_WRITE) begin
                            is_write <= 1'b1;
                            hold_q   <= 1'b1;
                        end else if (rx_dout == CMD_RUN) begin
                            is_write <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_ADDR_H: addr_h <= rx_dout;
                    // Frame address bits above ADDR_WIDTH are dropped here
                    ST_ADDR_L: addr_q <= ADDR_WIDTH'({addr_h, rx_dout});
                    ST_LEN_H:  len_q[15:8] <= rx_dout;
                    ST_LEN_L:  len_q[7:0]  <= rx_dout;
                    ST_DATA:   wdata_q <= rx_dout;
                    ST_CHK: begin
                        if (sum_next == 8'h00) begin
                            if (!is_write) begin
                                boot_q <= addr_q;
                                hold_q <= 1'b0;
                                run_q  <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (wr_accept) begin
                addr_q <= addr_q + 1'b1;
                len_q  <= len_q - 16'd1;
            end
        end
    end

    // Output mapping; mem_we is decoded from state so it drops with the async reset
    always_comb begin
        rx_re     = accept;
        mem_we    = (state == ST_WRITE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        boot_addr = boot_q;
        cpu_hold  = hold_q;
        run       = run_q;
        busy      = (state != ST_IDLE);
        err       = err_q;
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against uart_loader (ADDR_WIDTH=8, TIMEOUT_CLKS=100).
module tb_uart_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_dout;
    logic       rx_full;
    logic       rx_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_ready;
    logic       cpu_hold;
    logic [7:0] boot_addr;
    logic       run;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int run_count = 0;
    int stall_cycles = 0;
    int stall_cnt = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];

    uart_loader #(
        .ADDR_WIDTH  (8),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_dout  (rx_dout),
        .rx_full  (rx_full),
        .rx_re    (rx_re),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_ready(mem_ready),
        .cpu_hold (cpu_hold),
        .boot_addr(boot_addr),
        .run      (run),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Receiver model: present a byte, wait (bounded) for rx_re, drop full after the consuming edge
    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        rx_dout = b;
        rx_full = 1'b1;
        #1;
        k = 0;
        while (!rx_re && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!rx_re) check("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_full = 1'b0;
    endtask

    // Memory model: optional stall, compares each requested write against the expected queue
    always @(negedge clk) begin
        if (run) run_count++;
        if (mem_we) begin
            check("rx_re_in_write", rx_re, 0);
            if (exp_a.size() == 0) begin
                check("unexpected_we", 1, 0);
                mem_ready = 1'b1;
            end else begin
                check("wr_addr", mem_addr, exp_a[0]);
                check("wr_data", mem_wdata, exp_d[0]);
                if (stall_cnt < stall_cycles) begin
                    mem_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    stall_cnt = 0;
                    void'(exp_a.pop_front());
                    void'(exp_d.pop_front());
                    n_writes++;
                end
            end
        end else begin
            stall_cnt = 0;
            mem_ready = (stall_cycles == 0);
        end
    end

    initial begin
        rst_n     = 1'b0;
        rx_full   = 1'b0;
        rx_dout   = 8'h00;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_re", rx_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_boot_addr", boot_addr, 8'h00);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Valid write, two bytes at 0x10; checksum 01+00+10+00+02+AA+BB+88 = 0x200
        exp_a.push_back(8'h10); exp_d.push_back(8'hAA);
        exp_a.push_back(8'h11); exp_d.push_back(8'hBB);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h88);
        repeat (3) @(posedge clk);
        #1;
        check("wr1_count", n_writes, 2);
        check("wr1_pending", exp_a.size(), 0);
        check("wr1_err", err, 0);
        check("wr1_cpu_hold", cpu_hold, 1);
        check("wr1_busy", busy, 0);
        check("wr1_run_count", run_count, 0);

        // RUN to 0x0140; upper bits dropped with 8-bit address -> 0x40
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h01); send_byte(8'h40);
        send_byte(8'hBD);
        check("run_pulse", run, 1);
        check("run_cpu_hold", cpu_hold, 0);
        check("run_boot_addr", boot_addr, 8'h40);
        @(posedge clk);
        #1;
        check("run_pulse_end", run, 0);
        repeat (2) @(posedge clk);
        #1;
        check("run_count", run_count, 1);
        check("run_err", err, 0);

        // Bad checksum RUN
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("badchk_err", err, 1);
        check("badchk_run_count", run_count, 1);
        check("badchk_cpu_hold", cpu_hold, 0);
        check("badchk_boot_addr", boot_addr, 8'h40);

        // Sync clears err; LEN=0 write frame produces no write
        send_byte(8'h55);
        check("sync_clears_err", err, 0);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'hFF);
        repeat (2) @(posedge clk);
        #1;
        check("len0_err", err, 0);
        check("len0_cpu_hold", cpu_hold, 1);
        check("len0_writes", n_writes, 2);
        check("len0_busy", busy, 0);

        // Backpressure and address wrap: 0xFF then 0x00, 20-cycle stall each
        stall_cycles = 20;
        exp_a.push_back(8'hFF); exp_d.push_back(8'h11);
        exp_a.push_back(8'h00); exp_d.push_back(8'h22);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hCB);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_count", n_writes, 4);
        check("wrap_pending", exp_a.size(), 0);
        check("wrap_err", err, 0);
        stall_cycles = 0;

        // Timeout: last byte edge E0, expiry transition at E100
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00);
        repeat (99) @(posedge clk);
        #1;
        check("tmo_busy_before", busy, 1);
        check("tmo_err_before", err, 0);
        @(posedge clk);
        #1;
        check("tmo_busy_after", busy, 0);
        check("tmo_err_after", err, 1);
        send_byte(8'h12); send_byte(8'h34);
        @(posedge clk);
        #1;
        check("garbage_busy", busy, 0);
        check("garbage_err", err, 1);

        // Unknown command
        send_byte(8'h55);
        check("unk_sync_err", err, 0);
        send_byte(8'h07);
        check("unk_err", err, 1);
        check("unk_busy", busy, 0);

        // Async reset while a write is stalled
        stall_cycles = 20;
        exp_a.push_back(8'h30); exp_d.push_back(8'h44);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h44);
        repeat (3) @(negedge clk);
        check("pre_rst_we", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_rx_re", rx_re, 0);
        check("arst_mem_addr", mem_addr, 8'h00);
        check("arst_mem_wdata", mem_wdata, 8'h00);
        check("arst_boot_addr", boot_addr, 8'h00);
        check("arst_cpu_hold", cpu_hold, 1);
        check("arst_run", run, 0);
        check("arst_err", err, 0);
        exp_a.delete();
        exp_d.delete();
        stall_cycles = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_writes", n_writes, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
